// File: rtl/tff_reduce_pkg.sv
// Shared types and helpers for the toggle-flop reduction bank.
// Reduction modes, FSM states and the mux_out bit-index mapping.
package tff_reduce_pkg;

  typedef enum logic [1:0] {
    RED_XOR  = 2'd0,
    RED_AND  = 2'd1,
    RED_OR   = 2'd2,
    RED_ZERO = 2'd3
  } red_mode_e;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SWITCH = 1'b1
  } fsm_state_e;

  // Output bits are lane-major: all groups of lane 0, then lane 1, ...
  function automatic int out_idx(input int lane, input int grp, input int num_groups);
    return lane * num_groups + grp;
  endfunction

endpackage

// File: rtl/tff_lane.sv
// One LANES-wide toggle register: clears synchronously, inverts when enabled.
module tff_lane #(
  parameter int LANES = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [LANES-1:0] q
);

  logic [LANES-1:0] q_reg;

  // Toggle every bit of the member together when enabled.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= ~q_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/tff_reduce_bank.sv
// Toggle-flop bank with a registered, run-time selectable per-group reduction
// and a valid/ready mode-change handshake.
// Optional feature macro: TFF_REDUCE_ACT_CNT_EN enables the saturating
// mux_out activity counter; without it act_cnt is tied to 0.
module tff_reduce_bank
  import tff_reduce_pkg::*;
#(
  parameter int NUM_GROUPS = 4,
  parameter int DEPTH      = 4,
  parameter int LANES      = 5,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        t,
  input  logic [NUM_GROUPS*DEPTH-1:0] ch_en,
  input  logic                        mode_valid,
  input  logic [1:0]                  mode,
  output logic                        mode_ready,
  output logic [NUM_GROUPS*LANES-1:0] mux_out,
  output logic                        out_valid,
  input  logic                        cnt_clr,
  output logic [CNT_W-1:0]            act_cnt
);

  localparam int NUM_MEMBERS = NUM_GROUPS * DEPTH;
  localparam int OUT_W       = NUM_GROUPS * LANES;

  logic [LANES-1:0] q_bank [NUM_MEMBERS];
  logic [OUT_W-1:0] red_next;
  logic [OUT_W-1:0] mux_out_reg;
  red_mode_e        mode_reg;
  fsm_state_e       state_reg;

  generate
    for (genvar gi = 0; gi < NUM_MEMBERS; gi++) begin : g_member
      tff_lane #(.LANES(LANES)) u_lane (
        .clk (clk),
        .clr (clr),
        .en  (t & ch_en[gi]),
        .q   (q_bank[gi])
      );
    end
  endgenerate

  logic acc_xor, acc_and, acc_or;

  // Reduce each group's members lane by lane under the active mode.
  always_comb begin
    red_next = '0;
    acc_xor  = 1'b0;
    acc_and  = 1'b1;
    acc_or   = 1'b0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      for (int l = 0; l < LANES; l++) begin
        acc_xor = 1'b0;
        acc_and = 1'b1;
        acc_or  = 1'b0;
        for (int d = 0; d < DEPTH; d++) begin
          acc_xor = acc_xor ^ q_bank[g*DEPTH+d][l];
          acc_and = acc_and & q_bank[g*DEPTH+d][l];
          acc_or  = acc_or  | q_bank[g*DEPTH+d][l];
        end
        case (mode_reg)
          RED_XOR: red_next[out_idx(l, g, NUM_GROUPS)] = acc_xor;
          RED_AND: red_next[out_idx(l, g, NUM_GROUPS)] = acc_and;
          RED_OR:  red_next[out_idx(l, g, NUM_GROUPS)] = acc_or;
          default: red_next[out_idx(l, g, NUM_GROUPS)] = 1'b0;
        endcase
      end
    end
  end

  // Register the reduction every cycle; the output is never frozen.
  always_ff @(posedge clk) begin
    if (clr) begin
      mux_out_reg <= '0;
    end else begin
      mux_out_reg <= red_next;
    end
  end

  // Mode handshake: accept in RUN, then spend one SWITCH cycle before RUN.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= ST_RUN;
      mode_reg  <= RED_XOR;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (mode_valid) begin
            mode_reg  <= red_mode_e'(mode);
            state_reg <= ST_SWITCH;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign mux_out    = mux_out_reg;
  assign out_valid  = (state_reg == ST_RUN);
  assign mode_ready = (state_reg == ST_RUN) & ~clr;

`ifdef TFF_REDUCE_ACT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] act_cnt_reg;

  // Count RUN cycles whose next output differs from the current one; saturate.
  always_ff @(posedge clk) begin
    if (clr || cnt_clr) begin
      act_cnt_reg <= '0;
    end else if ((state_reg == ST_RUN) && (red_next != mux_out_reg) &&
                 (act_cnt_reg != '1)) begin
      act_cnt_reg <= act_cnt_reg + CNT_ONE;
    end
  end

  assign act_cnt = act_cnt_reg;
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign act_cnt        = '0;
`endif

endmodule
